bitslam_bus_arb: RTL

BITSLAM_BUS_ARB -- requirements
Module: bitslam_bus_arb

---
 rtl/bitslam_bus_arb.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bitslam_bus_arb.sv
// ---------------------------------------------------------------------------
// bitslam_bus_arb
//
// Round-robin arbiter that lets NREQ requesters share the synth configuration
// bus. The bus is a 6-bit addr_data value plus a select line. Every write
// takes two phases: first the address (bus_sel=0), then the data (bus_sel=1).
// Each write is acknowledged with a one-cycle pulse on that requester's ack bit.
//
// Optional feature (macro BITSLAM_ADDR_CACHE_EN):
//   A write to the address that was written last skips the address phase.
//   The downstream latch already holds that address.
//
// Parameters:
//   NREQ      number of requesters, 2..8 (default 4)
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   req       per-requester write request level, held until ack
//   req_addr  requester i register address in bits [6i+5:6i]
//   req_data  requester i write data in bits [6i+5:6i]
//   ack       one-cycle completion pulse, one-hot
//   bus_sel   0 = address phase, 1 = data phase
//   bus_val   value driven onto the synth addr_data bus
//   busy      high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module bitslam_bus_arb #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [6*NREQ-1:0] req_addr,
  input  logic [6*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              bus_sel,
  output logic [5:0]        bus_val,
  output logic              busy
);

  localparam int             PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]    NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0]  LAST   = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   grant, grant_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [5:0]      lat_addr, lat_addr_nxt;
  logic [5:0]      lat_data, lat_data_nxt;
  logic [5:0]      last_addr, last_addr_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic            bus_sel_nxt;
  logic [5:0]      bus_val_nxt;
  logic            busy_nxt;
`ifdef BITSLAM_ADDR_CACHE_EN
  logic            cache_valid, cache_valid_nxt;
`endif

  logic [5:0]      addr_arr [NREQ];
  logic [5:0]      data_arr [NREQ];
  logic            found;
  logic [PW-1:0]   pick;
  logic [PW:0]     sum;

  // Split the flat address/data buses into per-requester fields.
  // Requester i can then be selected by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = req_addr[6*i +: 6];
      data_arr[i] = req_data[6*i +: 6];
    end
  end

  // Round-robin search: scan from rr_ptr upward, wrapping at NREQ-1.
  // The first asserted request found wins. The sum is one bit wider
  // than the pointer, so the wrap can be detected before it is folded back.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && req[sum[PW-1:0]]) begin
        found = 1'b1;
        pick  = sum[PW-1:0];
      end
    end
  end

  // Next-state logic and next output values.
  // The outputs are computed from the state being entered, and then
  // registered. So the bus always reflects the current state, and no
  // input reaches an output combinationally.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    lat_addr_nxt  = lat_addr;
    lat_data_nxt  = lat_data;
    last_addr_nxt = last_addr;
`ifdef BITSLAM_ADDR_CACHE_EN
    cache_valid_nxt = cache_valid;
`endif

    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt    = pick;
          lat_addr_nxt = addr_arr[pick];
          lat_data_nxt = data_arr[pick];
          state_nxt    = ADDR;
`ifdef BITSLAM_ADDR_CACHE_EN
          if (cache_valid && (addr_arr[pick] == last_addr)) state_nxt = DATA;
`endif
        end
      end
      ADDR: state_nxt = DATA;
      DATA: begin
        state_nxt     = IDLE;
        last_addr_nxt = lat_addr;
        rr_ptr_nxt    = (grant == LAST) ? '0 : grant + 1'b1;
`ifdef BITSLAM_ADDR_CACHE_EN
        cache_valid_nxt = 1'b1;
`endif
      end
      default: state_nxt = IDLE;
    endcase

    ack_nxt     = '0;
    bus_sel_nxt = 1'b0;
    bus_val_nxt = last_addr_nxt;
    busy_nxt    = (state_nxt != IDLE);
    case (state_nxt)
      ADDR: bus_val_nxt = lat_addr_nxt;
      DATA: begin
        bus_sel_nxt        = 1'b1;
        bus_val_nxt        = lat_data_nxt;
        ack_nxt[grant_nxt] = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers.
  // Reset aborts any transaction in flight without issuing an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      last_addr <= '0;
      ack       <= '0;
      bus_sel   <= 1'b0;
      bus_val   <= '0;
      busy      <= 1'b0;
`ifdef BITSLAM_ADDR_CACHE_EN
      cache_valid <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_data  <= lat_data_nxt;
      last_addr <= last_addr_nxt;
      ack       <= ack_nxt;
      bus_sel   <= bus_sel_nxt;
      bus_val   <= bus_val_nxt;
      busy      <= busy_nxt;
`ifdef BITSLAM_ADDR_CACHE_EN
      cache_valid <= cache_valid_nxt;
`endif
    end
  end

endmodule
